imem_loader: RTL

Program loader that writes the instruction memory the single-cycle CPU fetches from. It accepts a framed byte stream over a valid/ready handshake, packs little-endian bytes into 32-bit words, and writes them to consecutive instruction-memory word addresses. It verifies an XOR checksum and holds the CPU in reset (`cpu_run` low) until a load completes cleanly. It sits beside the CPU top; `cpu_run` drives the CPU's reset gating.

---
 rtl/imem_loader_pkg.sv | 24 ++
 rtl/imem_loader_byte_packer.sv | 31 +++
 rtl/imem_loader.sv | 133 +++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package imem_loader_pkg;

    localparam int LEN_W = 16;
    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        CSUM,
        DONE,
        ERR
    } loader_state_t;

    function automatic logic [7:0] csum_step(
        input logic [7:0] acc,
        input logic [7:0] b
    );
        return acc ^ b;
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs four little-endian bytes into one 32-bit word.
module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        push,
    input  logic [7:0]  data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  cnt;
    logic [31:0] sr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= 2'd0;
            sr  <= 32'd0;
        end else if (clear) begin
            cnt <= 2'd0;
        end else if (push) begin
            cnt <= cnt + 2'd1;
            sr  <= {data, sr[31:8]};
        end
    end

    // Word is presented together with its 4th byte, before it lands in sr.
    assign word_valid = push && (cnt == 2'd3);
    assign word       = {data, sr[31:8]};

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader for instruction memory; gates CPU reset
// until a frame with a matching XOR checksum has been written.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         ADDR_W    = 8,
    parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_run,
    output logic              load_ok,
    output logic              load_err
);

    localparam int unsigned CAP = 1 << ADDR_W;

    loader_state_t state;
    logic [7:0]    len_lo;
    logic [LEN_W-1:0] left;
    logic [7:0]    csum;

    logic             xfer;
    logic             hunting;
    logic             is_sync;
    logic             pk_clear;
    logic             pk_push;
    logic             word_valid;
    logic [31:0]      word;
    logic [LEN_W-1:0] len_n;

    assign xfer     = in_valid && in_ready;
    assign hunting  = (state == IDLE) || (state == DONE) || (state == ERR);
    assign is_sync  = (in_data == SYNC_BYTE);
    assign pk_clear = xfer && hunting && is_sync;
    assign pk_push  = xfer && (state == DATA);
    assign len_n    = {in_data, len_lo};

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (pk_clear),
        .push       (pk_push),
        .data       (in_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            len_lo     <= 8'd0;
            left       <= '0;
            csum       <= 8'd0;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
            cpu_run    <= 1'b0;
            load_ok    <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            imem_we  <= 1'b0;
            in_ready <= 1'b1;
            if (imem_we) begin
                imem_addr <= imem_addr + ADDR_W'(1);
            end
            if (xfer) begin
                unique case (state)
                    IDLE, DONE, ERR: begin
                        if (is_sync) begin
                            state     <= LEN0;
                            load_ok   <= 1'b0;
                            load_err  <= 1'b0;
                            cpu_run   <= 1'b0;
                            csum      <= 8'd0;
                            imem_addr <= '0;
                        end
                    end
                    LEN0: begin
                        len_lo <= in_data;
                        csum   <= csum_step(csum, in_data);
                        state  <= LEN1;
                    end
                    LEN1: begin
                        csum <= csum_step(csum, in_data);
                        if (len_n == '0) begin
                            state <= CSUM;
                        end else if (32'(len_n) > CAP) begin
                            state    <= ERR;
                            load_err <= 1'b1;
                        end else begin
                            state <= DATA;
                            left  <= len_n;
                        end
                    end
                    DATA: begin
                        csum <= csum_step(csum, in_data);
                        if (word_valid) begin
                            // One bubble per word keeps writes one cycle apart.
                            imem_we    <= 1'b1;
                            imem_wdata <= word;
                            in_ready   <= 1'b0;
                            left       <= left - LEN_W'(1);
                            if (left == LEN_W'(1)) begin
                                state <= CSUM;
                            end
                        end
                    end
                    CSUM: begin
                        if (in_data == csum) begin
                            state   <= DONE;
                            load_ok <= 1'b1;
                            cpu_run <= 1'b1;
                        end else begin
                            state    <= ERR;
                            load_err <= 1'b1;
                            cpu_run  <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
